// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 minterms of a 4-input function block, holding each vector for
// SETTLE cycles before sampling F, and scores the captured table against EXPECTED.
module truth_table_sweeper #(
    parameter int unsigned SETTLE   = 2,
    parameter logic [15:0] EXPECTED = 16'hAAF8,
    parameter bit          GRAY     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        F_in,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail,
    output logic        fail_valid
);

    // A settle time of 0 would never let the vector reach the block, so it is promoted to 1.
    localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 : SETTLE;
    localparam logic [3:0]  WLOAD      = 4'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [3:0]  abcd_q, abcd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [15:0] captured_q, captured_d;
    logic [4:0]  mismatch_q, mismatch_d;
    logic [3:0]  first_fail_q, first_fail_d;
    logic        fail_valid_q, fail_valid_d;

    logic [3:0]  m_cur;
    logic        miss;
    logic [4:0]  mismatch_next;

    function automatic logic [3:0] minterm(input logic [3:0] pos);
        return GRAY ? (pos ^ (pos >> 1)) : pos;
    endfunction

    assign m_cur         = minterm(cnt_q);
    assign miss          = (F_in != EXPECTED[m_cur]);
    assign mismatch_next = mismatch_q + {4'd0, miss};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wcnt_d       = wcnt_q;
        abcd_d       = abcd_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        captured_d   = captured_q;
        mismatch_d   = mismatch_q;
        first_fail_d = first_fail_q;
        fail_valid_d = fail_valid_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    captured_d   = 16'd0;
                    mismatch_d   = 5'd0;
                    first_fail_d = 4'd0;
                    fail_valid_d = 1'b0;
                    cnt_d        = 4'd0;
                    abcd_d       = minterm(4'd0);
                    wcnt_d       = WLOAD;
                end
            end
            S_RUN: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    captured_d[m_cur] = F_in;
                    mismatch_d        = mismatch_next;
                    if (miss && !fail_valid_q) begin
                        first_fail_d = m_cur;
                        fail_valid_d = 1'b1;
                    end
                    if (cnt_q == 4'd15) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (mismatch_next == 5'd0);
                        abcd_d  = 4'd0;
                    end else begin
                        cnt_d  = cnt_q + 4'd1;
                        abcd_d = minterm(cnt_q + 4'd1);
                        wcnt_d = WLOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            wcnt_q       <= 4'd0;
            abcd_q       <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            captured_q   <= 16'd0;
            mismatch_q   <= 5'd0;
            first_fail_q <= 4'd0;
            fail_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            abcd_q       <= abcd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            captured_q   <= captured_d;
            mismatch_q   <= mismatch_d;
            first_fail_q <= first_fail_d;
            fail_valid_q <= fail_valid_d;
        end
    end

    assign {A, B, C, D}  = abcd_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign captured      = captured_q;
    assign mismatch_cnt  = mismatch_q;
    assign first_fail    = first_fail_q;
    assign fail_valid    = fail_valid_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: four configurations (settle/order) swept against
// directed and random function-block truth tables, scored by a table-level model.
module tb_truth_table_sweeper;

    localparam logic [15:0] EXP = 16'hAAF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s [4];
    logic        f_s     [4];
    logic        a_s     [4];
    logic        b_s     [4];
    logic        c_s     [4];
    logic        d_s     [4];
    logic        busy_s  [4];
    logic        done_s  [4];
    logic        pass_s  [4];
    logic [15:0] cap_s   [4];
    logic [4:0]  mm_s    [4];
    logic [3:0]  ff_s    [4];
    logic        fv_s    [4];
    logic [15:0] ftab    [4];

    int settle_of [4] = '{2, 1, 5, 2};
    bit gray_of   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Function block under sweep: a lookup into the table chosen for each instance.
    assign f_s[0] = ftab[0][{a_s[0], b_s[0], c_s[0], d_s[0]}];
    assign f_s[1] = ftab[1][{a_s[1], b_s[1], c_s[1], d_s[1]}];
    assign f_s[2] = ftab[2][{a_s[2], b_s[2], c_s[2], d_s[2]}];
    assign f_s[3] = ftab[3][{a_s[3], b_s[3], c_s[3], d_s[3]}];

    truth_table_sweeper #(.SETTLE(2), .EXPECTED(EXP), .GRAY(1'b0)) u_s2 (
        .clk(clk), .rst(rst), .start(start_s[0]), .F_in(f_s[0]),
        .A(a_s[0]), .B(b_s[0]), .C(c_s[0]), .D(d_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .captured(cap_s[0]),
        .mismatch_cnt(mm_s[0]), .first_fail(ff_s[0]), .fail_valid(fv_s[0]));

    truth_table_sweeper #(.SETTLE(1), .EXPECTED(EXP), .GRAY(1'b0)) u_s1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .F_in(f_s[1]),
        .A(a_s[1]), .B(b_s[1]), .C(c_s[1]), .D(d_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .captured(cap_s[1]),
        .mismatch_cnt(mm_s[1]), .first_fail(ff_s[1]), .fail_valid(fv_s[1]));

    truth_table_sweeper #(.SETTLE(5), .EXPECTED(EXP), .GRAY(1'b0)) u_s5 (
        .clk(clk), .rst(rst), .start(start_s[2]), .F_in(f_s[2]),
        .A(a_s[2]), .B(b_s[2]), .C(c_s[2]), .D(d_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .captured(cap_s[2]),
        .mismatch_cnt(mm_s[2]), .first_fail(ff_s[2]), .fail_valid(fv_s[2]));

    truth_table_sweeper #(.SETTLE(2), .EXPECTED(EXP), .GRAY(1'b1)) u_gray (
        .clk(clk), .rst(rst), .start(start_s[3]), .F_in(f_s[3]),
        .A(a_s[3]), .B(b_s[3]), .C(c_s[3]), .D(d_s[3]),
        .busy(busy_s[3]), .done(done_s[3]), .pass(pass_s[3]), .captured(cap_s[3]),
        .mismatch_cnt(mm_s[3]), .first_fail(ff_s[3]), .fail_valid(fv_s[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] visit(input bit g, input int k);
        int v;
        v = g ? (k ^ (k >> 1)) : k;
        return 4'(v);
    endfunction

    function automatic int ones(input logic [15:0] v);
        int n = 0;
        for (int k = 0; k < 16; k++) n += int'(v[k]);
        return n;
    endfunction

    task automatic chk_zero(input int i, input string tag);
        chk($sformatf("%s_abcd%0d", tag, i), {a_s[i], b_s[i], c_s[i], d_s[i]}, 0);
        chk($sformatf("%s_busy%0d", tag, i), busy_s[i], 0);
        chk($sformatf("%s_done%0d", tag, i), done_s[i], 0);
        chk($sformatf("%s_pass%0d", tag, i), pass_s[i], 0);
        chk($sformatf("%s_cap%0d", tag, i), cap_s[i], 0);
        chk($sformatf("%s_mm%0d", tag, i), mm_s[i], 0);
        chk($sformatf("%s_ff%0d", tag, i), ff_s[i], 0);
        chk($sformatf("%s_fv%0d", tag, i), fv_s[i], 0);
    endtask

    // One full sweep on instance i; pulse_at >= 0 re-asserts start on edge E0+pulse_at.
    task automatic run_sweep(input int i, input logic [15:0] tab, input int pulse_at);
        int          s;
        bit          g;
        int          nvec;
        logic [15:0] mask;
        logic [15:0] diff;
        int          exp_mm;
        logic [3:0]  exp_ff;
        bit          exp_fv;
        s      = settle_of[i];
        g      = gray_of[i];
        diff   = tab ^ EXP;
        exp_mm = ones(diff);
        exp_fv = (diff != 16'd0);
        exp_ff = 4'd0;
        for (int k = 15; k >= 0; k--) if (diff[visit(g, k)]) exp_ff = visit(g, k);
        ftab[i] = tab;
        @(negedge clk);
        start_s[i] = 1'b1;
        @(posedge clk);
        #1;
        start_s[i] = 1'b0;
        for (int c = 0; c < 16 * s; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            nvec = c / s;
            mask = 16'd0;
            for (int k = 0; k < nvec; k++) mask[visit(g, k)] = 1'b1;
            chk($sformatf("i%0d_c%0d_abcd", i, c), {a_s[i], b_s[i], c_s[i], d_s[i]}, visit(g, nvec));
            chk($sformatf("i%0d_c%0d_busy", i, c), busy_s[i], 1);
            chk($sformatf("i%0d_c%0d_done", i, c), done_s[i], 0);
            chk($sformatf("i%0d_c%0d_cap", i, c), cap_s[i], tab & mask);
            start_s[i] = (pulse_at >= 0) && (c + 1 == pulse_at);
        end
        @(posedge clk);
        #1;
        for (int h = 0; h < 2; h++) begin
            chk($sformatf("i%0d_h%0d_done", i, h), done_s[i], 1);
            chk($sformatf("i%0d_h%0d_busy", i, h), busy_s[i], 0);
            chk($sformatf("i%0d_h%0d_abcd", i, h), {a_s[i], b_s[i], c_s[i], d_s[i]}, 0);
            chk($sformatf("i%0d_h%0d_cap", i, h), cap_s[i], tab);
            chk($sformatf("i%0d_h%0d_mm", i, h), mm_s[i], exp_mm);
            chk($sformatf("i%0d_h%0d_pass", i, h), pass_s[i], exp_mm == 0);
            chk($sformatf("i%0d_h%0d_fv", i, h), fv_s[i], exp_fv);
            if (exp_fv) chk($sformatf("i%0d_h%0d_ff", i, h), ff_s[i], exp_ff);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [15:0] tab;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_s[i] = 1'b0;
            ftab[i]    = EXP;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk_zero(i, "rst");
        @(negedge clk);
        rst = 1'b0;

        run_sweep(0, EXP, -1);
        run_sweep(0, 16'hFFFF, -1);
        run_sweep(0, EXP ^ 16'h0050, -1);
        run_sweep(3, EXP ^ 16'h0050, -1);
        run_sweep(1, EXP, -1);
        run_sweep(2, EXP, -1);
        run_sweep(0, EXP, 10);
        run_sweep(0, EXP, -1);
        run_sweep(3, 16'h0000, -1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(1) == 0) tab = 16'($urandom);
                else tab = EXP ^ (16'd1 << $urandom_range(15));
                run_sweep(i, tab, -1);
            end
        end

        // Reset in the middle of a sweep, with start held through and after reset.
        ftab[0] = EXP;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("mid_busy", busy_s[0], 1);
        rst        = 1'b1;
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        chk_zero(0, "midrst");
        @(posedge clk);
        #1;
        chk_zero(0, "rsthold");
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        chk("restart_busy", busy_s[0], 1);
        chk("restart_cap", cap_s[0], 0);
        for (int k = 0; k < 40; k++) begin
            if (done_s[0]) break;
            @(posedge clk);
            #1;
        end
        chk("restart_done", done_s[0], 1);
        chk("restart_cap_final", cap_s[0], EXP);
        chk("restart_pass", pass_s[0], 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequencer that exhaustively exercises one 4-input combinational function block (inputs A,B,C,D with A as MSB; output F) on silicon or in a bench.
- Steps through all 16 minterms, holding each for a programmable settle time, then samples F.
- Builds the captured truth table and compares it against the expected 16-bit truth table.
- Reports pass/fail, mismatch count and first failing minterm.
- Sits between a test controller (start/done handshake) and the function block under sweep.

Parameters:
SETTLE, 2, cycles each vector is held before F is sampled; legal range 1..15; 0 is treated as 1
EXPECTED, 16'hAAF8, expected truth table; bit i = F for minterm i = {A,B,C,D}; default is F=0 at minterms 0,1,2,8,10,12,14
GRAY, 0, sweep order: 0 = binary count 0..15; 1 = reflected Gray order (minterm = cnt ^ (cnt>>1))

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request a sweep; sampled each edge
F_in  in  1  output F of the function block under sweep
A  out  1  function input, minterm bit 3 (registered)
B  out  1  function input, minterm bit 2 (registered)
C  out  1  function input, minterm bit 1 (registered)
D  out  1  function input, minterm bit 0 (registered)
busy  out  1  sweep in progress
done  out  1  sweep complete; results valid
pass  out  1  valid with done; 1 iff mismatch_cnt == 0
captured  out  16  sampled truth table; bit i = F_in observed for minterm i
mismatch_cnt  out  5  number of minterms where F_in != EXPECTED[i]; range 0..16
first_fail  out  4  first mismatching minterm, in sweep order
fail_valid  out  1  at least one mismatch recorded

Behaviour:
- States: IDLE, RUN, DONE. Internal counters: cnt[3:0] (sweep position) and wcnt[3:0] (settle countdown). Current minterm m = GRAY ? cnt^(cnt>>1) : cnt.
- Reset, and on every edge with rst=1: state IDLE. All outputs 0, including A..D, busy, done, pass, captured, mismatch_cnt, first_fail and fail_valid. cnt=0, wcnt=0. rst has priority over start.
- Start edge (call it E0): start=1 in IDLE or DONE.
  - State becomes RUN; busy=1, done=0, pass=0.
  - captured, mismatch_cnt, first_fail and fail_valid are cleared.
  - cnt=0; {A,B,C,D} = minterm for cnt 0; wcnt = SETTLE-1.
- start while RUN is ignored. It has no effect on the sweep and is not queued.
- RUN, each edge:
  - If wcnt != 0: wcnt decrements; A..D are unchanged.
  - If wcnt == 0 (sample edge):
    - captured[m] <= F_in.
    - If F_in != EXPECTED[m]: mismatch_cnt increments. If fail_valid is 0, first_fail <= m and fail_valid <= 1. Later mismatches never overwrite first_fail.
    - If cnt == 15: state DONE; busy=0, done=1, pass = (final mismatch_cnt == 0, including the current sample); A..D = 0.
    - Otherwise: cnt increments; A..D = next minterm; wcnt = SETTLE-1.
- Timing:
  - Vector k is driven from edge E0+k*SETTLE and sampled at edge E0+(k+1)*SETTLE.
  - Each vector is held exactly SETTLE cycles.
  - done rises after edge E0+16*SETTLE.
- DONE: done, pass and all results hold until start (new sweep, results cleared at E0) or rst.
- captured bits that have not yet been sampled in the current sweep read 0.
- mismatch_cnt cannot overflow; its maximum is 16.
- Reset mid-sweep: everything clears on that edge and partial results are discarded. A new start is required.
- A..D change only at E0, at sample edges and on reset, so they never glitch relative to clk.

Test Plan:
- SETTLE=2, GRAY=0, bench models F correctly (F=0 at 0,1,2,8,10,12,14), pulse start → A..D step 0000,0001,…,1111, each held 2 cycles; done rises 32 cycles after E0; captured=16'hAAF8, pass=1, mismatch_cnt=0, fail_valid=0; A..D return to 0000.
- F_in stuck at 1 → captured=16'hFFFF, mismatch_cnt=7, first_fail=0, fail_valid=1, pass=0.
- F_in inverted at minterms 4 and 6 only:
  - GRAY=0 → first_fail=4, mismatch_cnt=2, captured=16'hAAA8.
  - GRAY=1 → A..D follow 0,1,3,2,6,7,5,4,12,…,8; first_fail=6; captured=16'hAAA8.
- SETTLE=1 and SETTLE=5 with a correct model → done at E0+16 and E0+80 respectively; each vector held exactly 1 and 5 cycles.
- start pulsed again at E0+10 during RUN → sweep unaffected, done still at E0+32. Then start in DONE → done drops at the next edge, results clear, and a second full sweep gives identical results.
- rst asserted at E0+13 → next edge: all outputs 0, state IDLE. With start held high and rst=1 for that same edge → remains IDLE. Sweep begins only on the first edge with rst=0 and start=1.
